// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: button conditioning, step timing, turn queue, level ramp,
// game-over detection and apple seed generation.
module snake_game_ctrl #(
  parameter logic [7:0]  SIZE_X      = 8'd10,
  parameter logic [7:0]  SIZE_Y      = 8'd10,
  parameter int unsigned FIELD_SIZE  = int'(SIZE_X) * int'(SIZE_Y) * 3,
  parameter int unsigned SBITS       = $clog2(int'(SIZE_X) * int'(SIZE_Y)),
  parameter logic [23:0] PERIOD_INIT = 24'd5_000_000,
  parameter logic [23:0] PERIOD_DEC  = 24'd500_000,
  parameter logic [23:0] PERIOD_MIN  = 24'd1_000_000,
  parameter logic [7:0]  LEVEL_STEPS = 8'd32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn_dir_i,
  input  logic                  btn_start_i,
  input  logic                  btn_pause_i,
  input  logic [FIELD_SIZE-1:0] field_i,
  output logic                  start_o,
  output logic                  step_o,
  output logic [1:0]            snake_dir_o,
  output logic [SBITS-1:0]      seed_o,
  output logic                  running_o,
  output logic                  game_over_o,
  output logic [3:0]            level_o
);

  localparam logic [15:0] LfsrInit    = 16'hACE1;
  // A floor of 2 keeps the direction commit (period-2) a reachable count.
  localparam logic [23:0] PeriodFloor = (PERIOD_MIN < 24'd2) ? 24'd2 : PERIOD_MIN;

  typedef enum logic [2:0] {StIdle, StStart, StRun, StCheck, StPause, StOver} state_e;

  state_e                state_q, state_d;
  logic [23:0]           cnt_q, cnt_d;
  logic [1:0]            dir_q, dir_d;
  logic [3:0]            level_q, level_d;
  logic [7:0]            step_cnt_q, step_cnt_d;
  logic [1:0]            q0_q, q0_d, q1_q, q1_d, qcnt_q, qcnt_d;
  logic [FIELD_SIZE-1:0] snap_q, snap_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [SBITS-1:0]      seed_q;

  logic [5:0] btn_raw, sync1_q, sync2_q, prev_q, btn_edge;
  logic       start_edge, pause_edge;
  logic       req_valid;
  logic [1:0] req_dir, ref_dir, base0, base1, base_cnt;
  logic       accept, is_step, commit;
  logic [27:0] dec_total, diff;
  logic [23:0] period;

  assign btn_raw    = {btn_pause_i, btn_start_i, btn_dir_i};
  assign btn_edge   = sync2_q & ~prev_q;
  assign start_edge = btn_edge[4];
  assign pause_edge = btn_edge[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Direction code equals the button bit index: up, right, down, left.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'd0;
    if (btn_edge[0])      req_dir = 2'd0;
    else if (btn_edge[1]) req_dir = 2'd1;
    else if (btn_edge[2]) req_dir = 2'd2;
    else if (btn_edge[3]) req_dir = 2'd3;
    else                  req_valid = 1'b0;
  end

  assign dec_total = 28'(level_q) * 28'(PERIOD_DEC);
  assign diff      = 28'(PERIOD_INIT) - dec_total;

  always_comb begin
    period = PeriodFloor;
    if (28'(PERIOD_INIT) > dec_total && diff >= 28'(PeriodFloor)) period = diff[23:0];
  end

  assign is_step = (state_q == StRun) && (cnt_q == period - 24'd1);
  // snake_dir must already hold the queue head while step is high.
  assign commit  = ((state_q == StRun && !pause_edge) || state_q == StCheck) &&
                   (cnt_q == period - 24'd2);

  always_comb begin
    base_cnt = qcnt_q;
    base0    = q0_q;
    base1    = q1_q;
    dir_d    = dir_q;
    ref_dir  = (qcnt_q == 2'd2) ? q1_q : (qcnt_q == 2'd1) ? q0_q : dir_q;
    if (state_q == StStart) begin
      base_cnt = 2'd0;
      ref_dir  = 2'd1;
      dir_d    = 2'd1;
    end else if (commit && qcnt_q != 2'd0) begin
      dir_d    = q0_q;
      base0    = q1_q;
      base_cnt = qcnt_q - 2'd1;
    end
    accept = req_valid && (state_q != StIdle) && (state_q != StOver) &&
             (req_dir != ref_dir) && ((req_dir ^ ref_dir) != 2'd2) && (base_cnt != 2'd2);
    q0_d   = base0;
    q1_d   = base1;
    qcnt_d = base_cnt;
    if (accept) begin
      if (base_cnt == 2'd0) q0_d = req_dir;
      else                  q1_d = req_dir;
      qcnt_d = base_cnt + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    step_cnt_d = step_cnt_q;
    snap_d     = snap_q;
    unique case (state_q)
      StIdle:  if (start_edge) state_d = StStart;
      StStart: begin
        cnt_d      = '0;
        level_d    = '0;
        step_cnt_d = '0;
        state_d    = StRun;
      end
      StRun: begin
        if (is_step) begin
          cnt_d   = '0;
          snap_d  = field_i;
          state_d = StCheck;
          if (step_cnt_q + 8'd1 == LEVEL_STEPS) begin
            step_cnt_d = '0;
            if (level_q != 4'd15) level_d = level_q + 4'd1;
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end else if (pause_edge) begin
          state_d = StPause;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      // The check cycle counts as the first cycle of the next period.
      StCheck: begin
        cnt_d   = cnt_q + 24'd1;
        state_d = (field_i == snap_q) ? StOver : StRun;
      end
      StPause: begin
        if (start_edge)      state_d = StStart;
        else if (pause_edge) state_d = StRun;
      end
      StOver:  if (start_edge) state_d = StStart;
      default: state_d = StIdle;
    endcase
  end

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dir_q      <= 2'd1;
      level_q    <= '0;
      step_cnt_q <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
      qcnt_q     <= '0;
      snap_q     <= '0;
      lfsr_q     <= LfsrInit;
      seed_q     <= LfsrInit[SBITS-1:0];
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      level_q    <= level_d;
      step_cnt_q <= step_cnt_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      qcnt_q     <= qcnt_d;
      snap_q     <= snap_d;
      lfsr_q     <= lfsr_d;
      seed_q     <= lfsr_q[SBITS-1:0];
    end
  end

  assign start_o     = (state_q == StStart);
  assign step_o      = is_step;
  assign snake_dir_o = dir_q;
  assign seed_o      = seed_q;
  assign running_o   = (state_q == StRun) || (state_q == StCheck);
  assign game_over_o = (state_q == StOver);
  assign level_o     = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized bench for snake_game_ctrl: a game-rule reference model schedules start,
// step and game-over events into a scoreboard that a separate monitor drains.
module tb_snake_game_ctrl;
  localparam logic [7:0] SX = 8'd4;
  localparam logic [7:0] SY = 8'd4;
  localparam int FS = 48;
  localparam int SB = 4;
  localparam int PI = 20, PD = 4, PM = 8, LS = 4;

  localparam int MIdle = 0, MStart = 1, MRun = 2, MCheck = 3, MPause = 4, MOver = 5;
  localparam int KStart = 0, KStep = 1, KOver = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btn_dir = '0;
  logic          btn_start = 1'b0, btn_pause = 1'b0;
  logic [FS-1:0] field = '0;
  logic          start_o, step_o, running_o, game_over_o;
  logic [1:0]    snake_dir_o;
  logic [SB-1:0] seed_o;
  logic [3:0]    level_o;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .SIZE_X(SX), .SIZE_Y(SY), .FIELD_SIZE(FS), .SBITS(SB),
    .PERIOD_INIT(24'(PI)), .PERIOD_DEC(24'(PD)), .PERIOD_MIN(24'(PM)), .LEVEL_STEPS(8'(LS))
  ) dut (
    .clk(clk), .rst(rst), .btn_dir_i(btn_dir), .btn_start_i(btn_start),
    .btn_pause_i(btn_pause), .field_i(field), .start_o(start_o), .step_o(step_o),
    .snake_dir_o(snake_dir_o), .seed_o(seed_o), .running_o(running_o),
    .game_over_o(game_over_o), .level_o(level_o)
  );

  typedef struct {int cyc; int kind; int dir; int lvl;} ev_t;
  ev_t exp_q[$];

  int checks = 0, errors = 0, cyc = 0;

  // Reference game state as seen during the current cycle.
  int          m_mode, m_cnt, m_dir, m_lvl, m_steps;
  int          m_turns[$];
  logic [FS-1:0] m_snap;
  logic [15:0] m_lfsr, m_seed;
  logic [5:0]  h0, h1, h2;
  bit          freeze = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int period_of(int lvl);
    int p = PI - lvl * PD;
    if (p < PM) p = PM;
    if (p < 2) p = 2;
    return p;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    int b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return 16'((l >> 1) | (b << 15));
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_cnt = 0; m_dir = 1; m_lvl = 0; m_steps = 0;
    m_turns.delete();
    m_lfsr = 16'hACE1; m_seed = 16'hACE1;
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  task automatic model_cycle(logic [5:0] e);
    int p = period_of(m_lvl);
    int req = -1;
    int nxt = m_mode;
    int refd;
    bit deq = 1'b0;
    bit full;
    if (e[0]) req = 0; else if (e[1]) req = 1; else if (e[2]) req = 2; else if (e[3]) req = 3;
    case (m_mode)
      MIdle: if (e[4]) nxt = MStart;
      MStart: begin
        exp_q.push_back('{cyc, KStart, 0, 0});
        m_turns.delete(); m_dir = 1; m_lvl = 0; m_steps = 0; m_cnt = 0;
        nxt = MRun;
      end
      MRun: begin
        if (m_cnt == p - 1) begin
          exp_q.push_back('{cyc, KStep, m_dir, m_lvl});
          m_snap = field; m_cnt = 0; m_steps++;
          if (m_steps == LS) begin
            m_steps = 0;
            if (m_lvl < 15) m_lvl++;
          end
          nxt = MCheck;
        end else if (e[5]) begin
          nxt = MPause;
        end else begin
          deq = (m_cnt == p - 2);
          m_cnt++;
        end
      end
      MCheck: begin
        deq = (m_cnt == p - 2);
        m_cnt++;
        if (field == m_snap) begin
          nxt = MOver;
          exp_q.push_back('{cyc + 1, KOver, 0, 0});
        end else begin
          nxt = MRun;
        end
      end
      MPause: if (e[4]) nxt = MStart; else if (e[5]) nxt = MRun;
      MOver: if (e[4]) nxt = MStart;
      default: nxt = MIdle;
    endcase
    refd = (m_turns.size() > 0) ? m_turns[$] : m_dir;
    full = (m_turns.size() == 2) && !deq;
    if (deq && m_turns.size() > 0) m_dir = m_turns.pop_front();
    if (req >= 0 && m_mode != MIdle && m_mode != MOver && req != refd && (req ^ refd) != 2 &&
        !full) m_turns.push_back(req);
    m_mode = nxt;
    m_seed = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // One clock cycle: check level outputs, drive next inputs, advance the model.
  task automatic tick(logic [3:0] d, bit s, bit p, bit r);
    logic [5:0] nb;
    logic [SB-1:0] exp_seed;
    exp_seed = m_seed[SB-1:0];
    chk("running", int'(running_o), int'(m_mode == MRun || m_mode == MCheck));
    chk("game_over", int'(game_over_o), int'(m_mode == MOver));
    chk("snake_dir", int'(snake_dir_o), m_dir);
    chk("level", int'(level_o), m_lvl);
    chk("seed", int'(seed_o), int'(exp_seed));
    nb = r ? 6'd0 : {p, s, d};
    {btn_pause, btn_start, btn_dir} = nb;
    rst = r;
    if (!freeze) field = field ^ {16'($urandom), $urandom | 32'd1};
    model_cycle(h1 & ~h2);
    h2 = h1; h1 = h0; h0 = nb;
    if (r) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      model_reset();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    bit   go_prev = 1'b0;
    int   kind;
    ev_t  e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("event_missing", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      chk("start_step_overlap", int'(start_o & step_o), 0);
      if (start_o || step_o || (game_over_o && !go_prev)) begin
        kind = start_o ? KStart : (step_o ? KStep : KOver);
        if (exp_q.size() == 0) begin
          chk("event_unexpected", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (kind == KStep) begin
            chk("step_dir", int'(snake_dir_o), e.dir);
            chk("step_level", int'(level_o), e.lvl);
          end
        end
      end
      go_prev = game_over_o;
    end
  end

  initial begin : stimulus
    logic [3:0] d;
    repeat (3) @(negedge clk);
    model_reset();
    chk("reset_start", int'(start_o), 0);
    chk("reset_step", int'(step_o), 0);
    chk("reset_dir", int'(snake_dir_o), 1);
    chk("reset_level", int'(level_o), 0);

    tick(4'd0, 1'b1, 1'b0, 1'b0);
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    idle(12);
    tick(4'b1000, 1'b0, 1'b0, 1'b0);        // left while heading right
    idle(10);
    tick(4'b0001, 1'b0, 1'b0, 1'b0);        // up, then left inside the same period
    idle(1);
    tick(4'b1000, 1'b0, 1'b0, 1'b0);
    idle(60);

    tick(4'd0, 1'b0, 1'b1, 1'b0);           // pause, hold, resume
    idle(100);
    tick(4'd0, 1'b0, 1'b1, 1'b0);
    idle(40);

    freeze = 1'b1;                          // stalled playfield ends the game
    idle(30);
    tick(4'b0100, 1'b1, 1'b0, 1'b0);
    freeze = 1'b0;
    idle(20);
    chk("restart_level", int'(level_o), 0);

    idle(400);                              // level ramp through the period floor

    tick(4'b0001, 1'b0, 1'b0, 1'b0);        // queued turn then reset
    idle(3);
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_dir", int'(snake_dir_o), 1);
    chk("rst_running", int'(running_o), 0);
    chk("rst_seed", int'(seed_o), 1);       // low bits of 16'hACE1
    tick(4'd0, 1'b1, 1'b0, 1'b0);
    idle(40);

    for (int i = 0; i < 5000; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 399) == 0) freeze = ~freeze;
      tick(d, $urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 2999) == 0);
    end

    freeze = 1'b0;
    tick(4'd0, 1'b0, 1'b0, 1'b1);
    idle(10);
    #4;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
